// File: rtl/exmem_stage.sv
// EX/MEM pipeline register: captures ALU result, destination and store operand,
// and precomputes byte-enables, lane-shifted store data and misalignment.
module exmem_stage #(
  parameter int WordSize    = 32,
  parameter int RegAddrBits = 5
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   valid_in,
  input  logic [RegAddrBits-1:0] rdn_in,
  input  logic [WordSize-1:0]    alu_out_in,
  input  logic [WordSize-1:0]    rs2d,
  input  logic [1:0]             mem_op_in,
  input  logic [1:0]             mem_size_in,
  input  logic                   load_unsigned_in,
  output logic                   valid,
  output logic [RegAddrBits-1:0] rdn,
  output logic [WordSize-1:0]    alu_out,
  output logic [WordSize-1:0]    mem_data,
  output logic [WordSize/8-1:0]  mem_be,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [1:0]             mem_size,
  output logic                   load_unsigned,
  output logic                   misaligned
);

  localparam int NB     = WordSize / 8;
  localparam int OB     = $clog2(NB);
  // mem_size_in tops out at 3, so wider words never need clamping beyond that
  localparam int OB_SAT = (OB > 3) ? 3 : OB;

  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_STORE = 2'd2;

  logic [OB-1:0]       off;
  logic [1:0]          es;
  logic                is_load;
  logic                is_store;
  logic                is_mem;
  logic                mis;
  int                  n_bytes;
  logic [OB-1:0]       lane_mask;
  logic [NB-1:0]       size_be;
  logic [WordSize-1:0] size_mask;
  logic [NB-1:0]       be_shifted;
  logic [WordSize-1:0] data_shifted;

  assign off      = alu_out_in[OB-1:0];
  assign es       = (int'(mem_size_in) > OB_SAT) ? 2'(OB_SAT) : mem_size_in;
  assign is_load  = (mem_op_in == OP_LOAD);
  assign is_store = (mem_op_in == OP_STORE);
  assign is_mem   = is_load | is_store;

  always_comb begin
    n_bytes   = 1 << es;
    lane_mask = '0;
    size_be   = '0;
    size_mask = '0;
    for (int j = 0; j < OB; j++) begin
      lane_mask[j] = (j < int'(es));
    end
    for (int i = 0; i < NB; i++) begin
      size_be[i]         = (i < n_bytes);
      size_mask[8*i +: 8] = {8{size_be[i]}};
    end
  end

  assign mis          = is_mem & (|(off & lane_mask));
  assign be_shifted   = size_be << off;
  assign data_shifted = (rs2d & size_mask) << {off, 3'b000};

  // Priority: reset, then flush (beats stall), then stall holds, else capture.
  // A capture with valid_in low produces the same bubble as a flush.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid         <= 1'b0;
      rdn           <= '0;
      alu_out       <= '0;
      mem_data      <= '0;
      mem_be        <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_size      <= '0;
      load_unsigned <= 1'b0;
      misaligned    <= 1'b0;
    end else if (flush || (!stall && !valid_in)) begin
      valid         <= 1'b0;
      rdn           <= '0;
      alu_out       <= '0;
      mem_data      <= '0;
      mem_be        <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_size      <= '0;
      load_unsigned <= 1'b0;
      misaligned    <= 1'b0;
    end else if (!stall) begin
      valid         <= 1'b1;
      rdn           <= is_store ? '0 : rdn_in;
      alu_out       <= alu_out_in;
      mem_data      <= (is_store && !mis) ? data_shifted : '0;
      mem_be        <= (is_mem && !mis) ? be_shifted : '0;
      mem_read      <= is_load & ~mis;
      mem_write     <= is_store & ~mis;
      mem_size      <= es;
      load_unsigned <= load_unsigned_in;
      misaligned    <= mis;
    end
  end

endmodule

// File: tb/tb_exmem_stage.sv
// Directed bench for exmem_stage: 32-bit and 64-bit instances with
// hand-computed expected outputs.
module tb_exmem_stage;

  logic clk;
  logic rstn;
  logic stall;
  logic flush;

  // 32-bit instance
  logic        valid_in, lu_in;
  logic [4:0]  rdn_in;
  logic [31:0] alu_in, rs2d;
  logic [1:0]  op_in, size_in;
  logic        valid, mem_read, mem_write, lu, mis;
  logic [4:0]  rdn;
  logic [31:0] alu_out, mem_data;
  logic [3:0]  mem_be;
  logic [1:0]  mem_size;

  // 64-bit instance
  logic        v64_in, lu64_in;
  logic [4:0]  rdn64_in;
  logic [63:0] alu64_in, rs2d64;
  logic [1:0]  op64_in, size64_in;
  logic        v64, rd64, wr64, lu64, mis64;
  logic [4:0]  rdn64;
  logic [63:0] alu64, data64;
  logic [7:0]  be64;
  logic [1:0]  sz64;

  int n_vec;
  int n_bad;

  exmem_stage #(.WordSize(32), .RegAddrBits(5)) dut32 (
    .clk(clk), .rstn(rstn), .stall(stall), .flush(flush),
    .valid_in(valid_in), .rdn_in(rdn_in), .alu_out_in(alu_in), .rs2d(rs2d),
    .mem_op_in(op_in), .mem_size_in(size_in), .load_unsigned_in(lu_in),
    .valid(valid), .rdn(rdn), .alu_out(alu_out), .mem_data(mem_data),
    .mem_be(mem_be), .mem_read(mem_read), .mem_write(mem_write),
    .mem_size(mem_size), .load_unsigned(lu), .misaligned(mis)
  );

  exmem_stage #(.WordSize(64), .RegAddrBits(5)) dut64 (
    .clk(clk), .rstn(rstn), .stall(stall), .flush(flush),
    .valid_in(v64_in), .rdn_in(rdn64_in), .alu_out_in(alu64_in), .rs2d(rs2d64),
    .mem_op_in(op64_in), .mem_size_in(size64_in), .load_unsigned_in(lu64_in),
    .valid(v64), .rdn(rdn64), .alu_out(alu64), .mem_data(data64),
    .mem_be(be64), .mem_read(rd64), .mem_write(wr64),
    .mem_size(sz64), .load_unsigned(lu64), .misaligned(mis64)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one active edge, then settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive32(input logic v, input logic [1:0] op, input logic [1:0] sz,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] rd, input logic u);
    valid_in = v; op_in = op; size_in = sz; alu_in = addr; rs2d = data;
    rdn_in = rd; lu_in = u;
  endtask

  task automatic drive64(input logic v, input logic [1:0] op, input logic [1:0] sz,
                         input logic [63:0] addr, input logic [63:0] data,
                         input logic [4:0] rd);
    v64_in = v; op64_in = op; size64_in = sz; alu64_in = addr; rs2d64 = data;
    rdn64_in = rd; lu64_in = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rstn  = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    drive32(1'b1, 2'd2, 2'd2, 32'h1000, 32'hDEADBEEF, 5'd5, 1'b0);
    drive64(1'b0, 2'd0, 2'd0, 64'h0, 64'h0, 5'd0);
    step();
    check("reset_valid", 64'(valid), 64'h0);
    check("reset_alu", 64'(alu_out), 64'h0);
    rstn = 1'b1;

    // SW 0x1000
    step();
    check("sw_be", 64'(mem_be), 64'hF);
    check("sw_data", 64'(mem_data), 64'hDEADBEEF);
    check("sw_write", 64'(mem_write), 64'h1);
    check("sw_rdn", 64'(rdn), 64'h0);
    check("sw_valid", 64'(valid), 64'h1);

    // asynchronous reset between edges
    #2 rstn = 1'b0;
    #1;
    check("async_valid", 64'(valid), 64'h0);
    check("async_alu", 64'(alu_out), 64'h0);
    check("async_be", 64'(mem_be), 64'h0);
    check("async_data", 64'(mem_data), 64'h0);
    check("async_write", 64'(mem_write), 64'h0);
    #1 rstn = 1'b1;
    step();
    check("post_rst_alu", 64'(alu_out), 64'h1000);
    check("post_rst_valid", 64'(valid), 64'h1);

    // SB 0x1003
    drive32(1'b1, 2'd2, 2'd0, 32'h1003, 32'h123456AB, 5'd1, 1'b0);
    step();
    check("sb_be", 64'(mem_be), 64'h8);
    check("sb_data", 64'(mem_data), 64'hAB000000);

    // SH 0x1002
    drive32(1'b1, 2'd2, 2'd1, 32'h1002, 32'h123456AB, 5'd1, 1'b0);
    step();
    check("sh_be", 64'(mem_be), 64'hC);
    check("sh_data", 64'(mem_data), 64'h56AB0000);

    // LW 0x1002 misaligned
    drive32(1'b1, 2'd1, 2'd2, 32'h1002, 32'h0, 5'd7, 1'b0);
    step();
    check("lw_mis", 64'(mis), 64'h1);
    check("lw_mis_read", 64'(mem_read), 64'h0);
    check("lw_mis_be", 64'(mem_be), 64'h0);
    check("lw_mis_valid", 64'(valid), 64'h1);
    check("lw_mis_rdn", 64'(rdn), 64'h7);

    // LH 0x1001 misaligned
    drive32(1'b1, 2'd1, 2'd1, 32'h1001, 32'h0, 5'd7, 1'b0);
    step();
    check("lh_mis", 64'(mis), 64'h1);

    // LW 0x1004 aligned
    drive32(1'b1, 2'd1, 2'd2, 32'h1004, 32'hFFFFFFFF, 5'd3, 1'b0);
    step();
    check("lw_read", 64'(mem_read), 64'h1);
    check("lw_be", 64'(mem_be), 64'hF);
    check("lw_data", 64'(mem_data), 64'h0);
    check("lw_rdn", 64'(rdn), 64'h3);
    check("lw_size", 64'(mem_size), 64'h2);

    // stall three cycles while inputs change
    stall = 1'b1;
    drive32(1'b1, 2'd2, 2'd0, 32'h2001, 32'h55, 5'd9, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_alu", 64'(alu_out), 64'h1004);
      check("stall_read", 64'(mem_read), 64'h1);
      check("stall_be", 64'(mem_be), 64'hF);
      check("stall_data", 64'(mem_data), 64'h0);
      check("stall_rdn", 64'(rdn), 64'h3);
    end

    // flush beats stall
    flush = 1'b1;
    step();
    check("flush_valid", 64'(valid), 64'h0);
    check("flush_read", 64'(mem_read), 64'h0);
    check("flush_be", 64'(mem_be), 64'h0);
    flush = 1'b0;
    stall = 1'b0;

    // single-cycle pulse: LBU 0x3002
    drive32(1'b1, 2'd1, 2'd0, 32'h3002, 32'h0, 5'd9, 1'b1);
    step();
    check("lbu_valid", 64'(valid), 64'h1);
    check("lbu_be", 64'(mem_be), 64'h4);
    check("lbu_unsigned", 64'(lu), 64'h1);
    check("lbu_size", 64'(mem_size), 64'h0);
    valid_in = 1'b0;
    step();
    check("pulse_end_valid", 64'(valid), 64'h0);

    // stall during a bubble holds the bubble
    stall = 1'b1;
    drive32(1'b1, 2'd1, 2'd2, 32'h4000, 32'h0, 5'd2, 1'b0);
    step();
    check("stall_bubble_valid", 64'(valid), 64'h0);
    stall = 1'b0;

    // none-op keeps rdn
    drive32(1'b1, 2'd0, 2'd2, 32'h1234, 32'hFFFFFFFF, 5'd4, 1'b0);
    step();
    check("none_be", 64'(mem_be), 64'h0);
    check("none_data", 64'(mem_data), 64'h0);
    check("none_rdn", 64'(rdn), 64'h4);
    check("none_rw", 64'({mem_read, mem_write}), 64'h0);

    // size 3 clamped on 32-bit; also SD 0x2008 on 64-bit
    drive32(1'b1, 2'd2, 2'd3, 32'h1000, 32'hCAFEBABE, 5'd1, 1'b0);
    drive64(1'b1, 2'd2, 2'd3, 64'h2008, 64'h0123456789ABCDEF, 5'd1);
    step();
    check("clamp_size", 64'(mem_size), 64'h2);
    check("clamp_be", 64'(mem_be), 64'hF);
    check("clamp_mis", 64'(mis), 64'h0);
    check("clamp_data", 64'(mem_data), 64'hCAFEBABE);
    check("sd_be", 64'(be64), 64'hFF);
    check("sd_data", data64, 64'h0123456789ABCDEF);
    check("sd_size", 64'(sz64), 64'h3);

    // SW 0x2004 on 64-bit
    drive64(1'b1, 2'd2, 2'd2, 64'h2004, 64'hFFFFFFFFCAFEF00D, 5'd1);
    step();
    check("sw64_be", 64'(be64), 64'hF0);
    check("sw64_data", data64, 64'hCAFEF00D00000000);

    // SD 0x2004 misaligned on 64-bit
    drive64(1'b1, 2'd2, 2'd3, 64'h2004, 64'h1, 5'd1);
    step();
    check("sd64_mis", 64'(mis64), 64'h1);
    check("sd64_write", 64'(wr64), 64'h0);
    check("sd64_be", 64'(be64), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
